// File: rtl/trisc_pkg.sv
// Shared types for the TRISC control path: FSM states, opcode values and the
// opcode-class decode used by the sequencer.
package trisc_pkg;

    localparam int unsigned NumCtrl = 11;

    localparam logic [3:0] OpLoad  = 4'b1000;
    localparam logic [3:0] OpJump  = 4'b1001;
    localparam logic [3:0] OpStore = 4'b1100;
    localparam logic [3:0] OpHalt  = 4'b1111;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsLoad,
        ClsStore,
        ClsJump,
        ClsHalt,
        ClsIllegal
    } op_class_e;

    function automatic op_class_e op_class(input logic [3:0] opcode);
        op_class_e cls;
        case (opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0110, 4'b0111: cls = ClsAlu;
            OpLoad:                    cls = ClsLoad;
            OpStore:                   cls = ClsStore;
            OpJump:                    cls = ClsJump;
            OpHalt:                    cls = ClsHalt;
            default:                   cls = ClsIllegal;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Maps a 4-bit opcode onto one of eleven one-hot control lines; unmapped
// opcodes produce no line at all.
module instruction_decoder
    import trisc_pkg::*;
(
    input  logic [3:0]         opcode_i,
    output logic [NumCtrl-1:0] lines_o
);

    always_comb begin
        lines_o = '0;
        case (opcode_i)
            4'b0000: lines_o[0]  = 1'b1;
            4'b0001: lines_o[1]  = 1'b1;
            4'b0010: lines_o[2]  = 1'b1;
            4'b0011: lines_o[3]  = 1'b1;
            4'b0100: lines_o[4]  = 1'b1;
            4'b0110: lines_o[5]  = 1'b1;
            4'b0111: lines_o[6]  = 1'b1;
            OpLoad:  lines_o[7]  = 1'b1;
            OpJump:  lines_o[8]  = 1'b1;
            OpStore: lines_o[9]  = 1'b1;
            OpHalt:  lines_o[10] = 1'b1;
            default: lines_o     = '0;
        endcase
    end

endmodule

// File: rtl/trisc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the TRISC core; owns PC and IR
// and drives the req/ack memory port.
module trisc_control_fsm
    import trisc_pkg::*;
#(
    parameter int unsigned PCW = 4,
    parameter int unsigned IW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic               mem_we,
    output logic [PCW-1:0]     mem_addr,
    input  logic [IW-1:0]      mem_rdata,
    input  logic               mem_ack,
    output logic [PCW-1:0]     pc,
    output logic [IW-1:0]      ir,
    output logic [NumCtrl-1:0] ctrl,
    output logic               alu_en,
    output logic               reg_we,
    output logic               illegal,
    output logic               halted
);

    state_e             state_q, state_d;
    logic [PCW-1:0]     pc_q, pc_d;
    logic [IW-1:0]      ir_q, ir_d;
    logic [3:0]         opcode;
    logic [IW-5:0]      operand;
    logic [PCW-1:0]     operand_addr;
    op_class_e          cls;
    logic [NumCtrl-1:0] dec_lines;
    logic               mem_fire;

    assign opcode       = ir_q[IW-1 -: 4];
    assign operand      = ir_q[IW-5:0];
    assign operand_addr = PCW'(operand);
    assign cls          = op_class(opcode);

    instruction_decoder u_decoder (
        .opcode_i (opcode),
        .lines_o  (dec_lines)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Only a request the FSM is actually making can complete; stray acks are ignored.
    assign mem_fire = mem_req && mem_ack;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            StFetch: begin
                if (mem_fire) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + PCW'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (cls == ClsIllegal) begin
                    state_d = StFetch;
                end else if (cls == ClsHalt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (cls)
                    ClsAlu:             state_d = StWb;
                    ClsLoad, ClsStore:  state_d = StMem;
                    ClsJump: begin
                        pc_d    = operand_addr;
                        state_d = StFetch;
                    end
                    default:            state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_fire) begin
                    state_d = (cls == ClsLoad) ? StWb : StFetch;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Outputs depend on state, IR and the reset pin only; mem_ack never reaches them.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        ctrl     = '0;
        alu_en   = 1'b0;
        reg_we   = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req = !reset;
            end
            StDecode: begin
                illegal = (cls == ClsIllegal);
            end
            StExec: begin
                ctrl   = dec_lines;
                alu_en = (cls == ClsAlu);
            end
            StMem: begin
                ctrl     = dec_lines;
                mem_req  = !reset;
                mem_we   = !reset && (cls == ClsStore);
                mem_addr = operand_addr;
            end
            StWb: begin
                ctrl   = dec_lines;
                reg_we = 1'b1;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign pc = pc_q;
    assign ir = ir_q;

endmodule

// File: tb/tb_trisc_control_fsm.sv
// Directed bench for trisc_control_fsm: a table of single-instruction vectors
// driven through a cycle-accurate memory responder, plus halt and reset sequences.
module tb_trisc_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [3:0]  pc;
    logic [7:0]  ir;
    logic [10:0] ctrl;
    logic        alu_en;
    logic        reg_we;
    logic        illegal;
    logic        halted;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_pc;

    typedef struct {
        logic [7:0]  instr;
        int          fwait;
        int          mwait;
        int          cycles;
        logic [3:0]  pc_next;
        int          alu_n;
        int          rwe_n;
        int          ill_n;
        bit          has_mem;
        logic [3:0]  maddr;
        bit          mwe;
        logic [10:0] ctrl;
    } vec_t;

    trisc_control_fsm #(
        .PCW (4),
        .IW  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .ir        (ir),
        .ctrl      (ctrl),
        .alu_en    (alu_en),
        .reg_we    (reg_we),
        .illegal   (illegal),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at the falling edge of a FETCH cycle; leaves at the falling edge of the next one.
    task automatic exec_vec(input int idx, input vec_t v);
        int         alu_n = 0;
        int         rwe_n = 0;
        int         ill_n = 0;
        int         mcyc = 0;
        bit         fetch_ok = 1'b1;
        bit         mem_ok = 1'b1;
        bit         mem_seen = 1'b0;
        bit         multi = 1'b0;
        logic [10:0] ctrl_or = '0;
        for (int c = 0; c < v.cycles; c++) begin
            if (c <= v.fwait) begin
                if (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === exp_pc)) fetch_ok = 1'b0;
                mem_ack   = (c == v.fwait);
                mem_rdata = (c == v.fwait) ? v.instr : 8'hFF;
            end else if (mem_req === 1'b1) begin
                mem_seen = 1'b1;
                if (mem_addr !== v.maddr || mem_we !== v.mwe) mem_ok = 1'b0;
                mem_ack   = (mcyc == v.mwait);
                mem_rdata = 8'h3C;
                mcyc++;
            end else begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hAA;
            end
            alu_n += int'(alu_en);
            rwe_n += int'(reg_we);
            ill_n += int'(illegal);
            ctrl_or |= ctrl;
            if ((ctrl & (ctrl - 11'd1)) != 11'd0) multi = 1'b1;
            @(negedge clk);
        end
        chk($sformatf("v%0d fetch_port", idx), 32'(fetch_ok), 32'd1);
        chk($sformatf("v%0d ir", idx), 32'(ir), 32'(v.instr));
        chk($sformatf("v%0d pc", idx), 32'(pc), 32'(v.pc_next));
        chk($sformatf("v%0d next_req", idx), 32'(mem_req), 32'd1);
        chk($sformatf("v%0d next_addr", idx), 32'(mem_addr), 32'(v.pc_next));
        chk($sformatf("v%0d alu_en", idx), 32'(alu_n), 32'(v.alu_n));
        chk($sformatf("v%0d reg_we", idx), 32'(rwe_n), 32'(v.rwe_n));
        chk($sformatf("v%0d illegal", idx), 32'(ill_n), 32'(v.ill_n));
        chk($sformatf("v%0d ctrl", idx), 32'(ctrl_or), 32'(v.ctrl));
        chk($sformatf("v%0d ctrl_onehot", idx), 32'(multi), 32'd0);
        chk($sformatf("v%0d mem_phase", idx), 32'(mem_seen), 32'(v.has_mem));
        chk($sformatf("v%0d mem_port", idx), 32'(mem_ok), 32'd1);
        exp_pc = v.pc_next;
    endtask

    vec_t vecs[17];
    vec_t dly;
    bit   halt_ok;

    initial begin
        //          instr  fw mw cyc pc   alu rwe ill mem  maddr we ctrl
        vecs[0]  = '{8'h05, 0, 0, 4, 4'd1,  1, 1, 0, 1'b0, 4'h0, 1'b0, 11'h001};
        vecs[1]  = '{8'h10, 3, 0, 7, 4'd2,  1, 1, 0, 1'b0, 4'h0, 1'b0, 11'h002};
        vecs[2]  = '{8'h97, 0, 0, 3, 4'd7,  0, 0, 0, 1'b0, 4'h0, 1'b0, 11'h100};
        vecs[3]  = '{8'h83, 0, 0, 5, 4'd8,  0, 1, 0, 1'b1, 4'h3, 1'b0, 11'h080};
        vecs[4]  = '{8'hC4, 0, 2, 6, 4'd9,  0, 0, 0, 1'b1, 4'h4, 1'b1, 11'h200};
        vecs[5]  = '{8'h50, 0, 0, 2, 4'd10, 0, 0, 1, 1'b0, 4'h0, 1'b0, 11'h000};
        vecs[6]  = '{8'h6A, 0, 0, 4, 4'd11, 1, 1, 0, 1'b0, 4'h0, 1'b0, 11'h020};
        vecs[7]  = '{8'h7F, 1, 0, 5, 4'd12, 1, 1, 0, 1'b0, 4'h0, 1'b0, 11'h040};
        vecs[8]  = '{8'h8E, 0, 1, 6, 4'd13, 0, 1, 0, 1'b1, 4'hE, 1'b0, 11'h080};
        vecs[9]  = '{8'h4F, 0, 0, 4, 4'd14, 1, 1, 0, 1'b0, 4'h0, 1'b0, 11'h010};
        vecs[10] = '{8'hB0, 0, 0, 2, 4'd15, 0, 0, 1, 1'b0, 4'h0, 1'b0, 11'h000};
        vecs[11] = '{8'h2C, 0, 0, 4, 4'd0,  1, 1, 0, 1'b0, 4'h0, 1'b0, 11'h004};
        vecs[12] = '{8'h3C, 0, 0, 4, 4'd1,  1, 1, 0, 1'b0, 4'h0, 1'b0, 11'h008};
        vecs[13] = '{8'hD1, 0, 0, 2, 4'd2,  0, 0, 1, 1'b0, 4'h0, 1'b0, 11'h000};
        vecs[14] = '{8'hE2, 2, 0, 4, 4'd3,  0, 0, 1, 1'b0, 4'h0, 1'b0, 11'h000};
        vecs[15] = '{8'h9F, 0, 0, 3, 4'd15, 0, 0, 0, 1'b0, 4'h0, 1'b0, 11'h100};
        vecs[16] = '{8'h00, 0, 0, 4, 4'd0,  1, 1, 0, 1'b0, 4'h0, 1'b0, 11'h001};
        dly      = '{8'h05, 3, 0, 7, 4'd1,  1, 1, 0, 1'b0, 4'h0, 1'b0, 11'h001};

        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        exp_pc    = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst pc", 32'(pc), 32'd0);
        chk("rst ir", 32'(ir), 32'd0);
        chk("rst ctrl", 32'(ctrl), 32'd0);
        chk("rst pulses", 32'({alu_en, reg_we, illegal, halted}), 32'd0);
        reset = 1'b0;
        #1;
        chk("first req", 32'(mem_req), 32'd1);

        for (int i = 0; i < 17; i++) exec_vec(i, vecs[i]);

        // HALT at pc 0: stays halted with the memory port idle despite stray acks.
        mem_ack   = 1'b1;
        mem_rdata = 8'hF0;
        @(negedge clk);
        mem_rdata = 8'hAA;
        @(negedge clk);
        halt_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (halted !== 1'b1 || mem_req !== 1'b0) halt_ok = 1'b0;
            @(negedge clk);
        end
        chk("halt hold", 32'(halt_ok), 32'd1);
        chk("halt pc", 32'(pc), 32'd1);
        chk("halt ctrl", 32'(ctrl), 32'd0);

        // Reset, then interrupt a LOAD while its MEM ack is pending.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h85;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ld mem_req", 32'(mem_req), 32'd1);
        chk("ld mem_addr", 32'(mem_addr), 32'd5);
        mem_ack   = 1'b1;
        mem_rdata = 8'h11;
        #2;
        reset = 1'b1;
        #1;
        chk("async mem_req", 32'(mem_req), 32'd0);
        chk("async addr", 32'(mem_addr), 32'd0);
        chk("async pc_ir", 32'({pc, ir}), 32'd0);
        chk("async ctrl", 32'(ctrl), 32'd0);
        @(posedge clk);
        #1;
        chk("pending ack", 32'({pc, ir}), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b0;
        exp_pc  = 4'd0;
        #1;
        chk("restart req", 32'(mem_req), 32'd1);
        exec_vec(99, dly);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
